// File: rtl/reg_wb_sched_if.sv
// Writeback/issue bus for reg_wb_sched: two writeback requesters, an issue-stage
// reservation port with source-operand hazard check, and the register-file write port.
interface reg_wb_sched_if;
  logic        alu_vld;
  logic        alu_rdy;
  logic [3:0]  alu_rd;
  logic [15:0] alu_data;
  logic        ld_vld;
  logic        ld_rdy;
  logic [3:0]  ld_rd;
  logic [15:0] ld_data;
  logic        iss_vld;
  logic [3:0]  iss_rd;
  logic        iss_rdy;
  logic [3:0]  rn1;
  logic [3:0]  rn2;
  logic [3:0]  rn3;
  logic        read3;
  logic        stall;
  logic        reg_wr;
  logic [3:0]  wr;
  logic [15:0] wd;

  // Requesters / issue stage / register file side
  modport master (
    output alu_vld, alu_rd, alu_data, ld_vld, ld_rd, ld_data,
    output iss_vld, iss_rd, rn1, rn2, rn3, read3,
    input  alu_rdy, ld_rdy, iss_rdy, stall, reg_wr, wr, wd
  );

  // Scheduler side
  modport slave (
    input  alu_vld, alu_rd, alu_data, ld_vld, ld_rd, ld_data,
    input  iss_vld, iss_rd, rn1, rn2, rn3, read3,
    output alu_rdy, ld_rdy, iss_rdy, stall, reg_wr, wr, wd
  );
endinterface

// File: rtl/reg_wb_sched.sv
// Writeback scheduler: round-robin arbitration between ALU and load results onto a
// single registered register-file write port, plus a pending-register scoreboard
// that blocks WAW reservations and flags RAW hazards for the issue stage.
module reg_wb_sched (
  input logic          clk,
  input logic          rst,
  reg_wb_sched_if.slave bus
);

  typedef enum logic {GntAlu, GntLd} last_e;

  last_e       last_q, last_d;
  logic [15:0] pending_q, pending_d;
  logic        reg_wr_q;
  logic [3:0]  wr_q;
  logic [15:0] wd_q;
  logic        alu_gnt, ld_gnt, iss_acc;

  // Grant: single requester wins outright; on a tie the one not granted last wins
  always_comb begin
    alu_gnt = 1'b0;
    ld_gnt  = 1'b0;
    if (!rst) begin
      if (bus.alu_vld && bus.ld_vld) begin
        alu_gnt = (last_q == GntLd);
        ld_gnt  = (last_q == GntAlu);
      end else begin
        alu_gnt = bus.alu_vld;
        ld_gnt  = bus.ld_vld;
      end
    end
  end

  // Next-state: pointer moves only on a transfer; scoreboard clear first so set wins
  always_comb begin
    last_d    = last_q;
    pending_d = pending_q;
    iss_acc   = !rst && bus.iss_vld && !pending_q[bus.iss_rd];
    if (alu_gnt) begin
      last_d = GntAlu;
    end else if (ld_gnt) begin
      last_d = GntLd;
    end
    if (reg_wr_q) begin
      pending_d[wr_q] = 1'b0;
    end
    if (iss_acc) begin
      pending_d[bus.iss_rd] = 1'b1;
    end
  end

  // State and write-port registers; reset drops any write in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= GntLd;
      pending_q <= 16'h0000;
      reg_wr_q  <= 1'b0;
      wr_q      <= 4'h0;
      wd_q      <= 16'h0000;
    end else begin
      last_q    <= last_d;
      pending_q <= pending_d;
      reg_wr_q  <= alu_gnt | ld_gnt;
      if (alu_gnt) begin
        wr_q <= bus.alu_rd;
        wd_q <= bus.alu_data;
      end else if (ld_gnt) begin
        wr_q <= bus.ld_rd;
        wd_q <= bus.ld_data;
      end
    end
  end

  // Outputs
  assign bus.alu_rdy = alu_gnt;
  assign bus.ld_rdy  = ld_gnt;
  assign bus.iss_rdy = iss_acc;
  assign bus.stall   = pending_q[bus.rn1] | pending_q[bus.rn2] |
                       (bus.read3 & pending_q[bus.rn3]);
  assign bus.reg_wr  = reg_wr_q;
  assign bus.wr      = wr_q;
  assign bus.wd      = wd_q;

endmodule

// File: doc/reg_wb_sched.md
REG_WB_SCHED -- requirements
Module: reg_wb_sched

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 alu_vld  input  1  ALU writeback request valid.
REQ-004 alu_rdy  output  1  ALU request granted this cycle.
REQ-005 alu_rd  input  4  ALU destination register.
REQ-006 alu_data  input  16  ALU result.
REQ-007 ld_vld  input  1  load writeback request valid.
REQ-008 ld_rdy  output  1  load request granted this cycle.
REQ-009 ld_rd  input  4  load destination register.
REQ-010 ld_data  input  16  load data.
REQ-011 iss_vld  input  1  issue stage reserving a destination register.
REQ-012 iss_rd  input  4  register being reserved.
REQ-013 iss_rdy  output  1  reservation accepted this cycle.
REQ-014 rn1, rn2, rn3  input  4 each  source registers of the instruction in issue.
REQ-015 read3  input  1  rn3 is in use by that instruction.
REQ-016 stall  output  1  a used source register is pending.
REQ-017 reg_wr  output  1  register-file write enable, registered.
REQ-018 wr  output  4  register-file write address, registered.
REQ-019 wd  output  16  register-file write data, registered.

Function
REQ-020 A transfer SHALL occur on a requester when vld and rdy are both high at a rising clk edge; the requester holds vld, rd and data stable until that edge.
REQ-021 At most one of alu_rdy, ld_rdy SHALL be high in any cycle; both rdy outputs are combinational from vld inputs and arbitration state.
REQ-022 One requester valid: it SHALL be granted in the same cycle.
REQ-023 Both valid: the requester not granted most recently SHALL be granted (round-robin); the last-grant pointer SHALL update only on a transfer.
REQ-024 Neither valid: no grant; pointer unchanged.
REQ-025 A transfer at edge N SHALL drive reg_wr=1, wr=granted rd, wd=granted data for exactly the cycle after edge N (one-cycle latency); no transfer: reg_wr=0, and wr/wd SHALL hold their previous values.
REQ-026 A 16-bit pending vector SHALL hold one bit per register; all 16 registers are treated identically.
REQ-027 iss_rdy SHALL equal iss_vld AND NOT pending[iss_rd]; on an accepted reservation pending[iss_rd] SHALL set at that edge.
REQ-028 pending[wr] SHALL clear at the edge that ends a cycle with reg_wr=1.
REQ-029 Set and clear of the same register at one edge: set SHALL win (bit ends at 1).
REQ-030 A reservation to a register still pending (WAW) SHALL be refused (iss_rdy=0) until its clear edge; iss_rdy SHALL NOT consider a clear in progress that cycle.
REQ-031 A writeback to a non-pending register SHALL still be written; the pending bit stays 0.
REQ-032 stall SHALL equal pending[rn1] OR pending[rn2] OR (read3 AND pending[rn3]), combinational from current state.

Reset
REQ-033 While rst=1 at an edge: pending=16'h0000, reg_wr=0, wr=4'h0, wd=16'h0000, and the pointer SHALL be set so the ALU is favoured on the first tie.
REQ-034 While rst=1: alu_rdy, ld_rdy and iss_rdy SHALL be 0, and no transfer or reservation SHALL occur.
REQ-035 Reset asserted with a write pending in the output register: that write SHALL be dropped (reg_wr=0 in the next cycle).

Verification
REQ-036 Reset, then alu_vld=1 alu_rd=4'h3 alu_data=16'hABCD for one cycle -> alu_rdy=1 that cycle; next cycle reg_wr=1 wr=3 wd=ABCD; cycle after that, reg_wr=0.
REQ-037 After reset, both valid for 4 cycles (alu rd=1 data=1111; ld rd=2 data=2222, each dropping vld after its own transfer) -> grants ALU then LD; writes to r1 then r2 on consecutive cycles.
REQ-038 iss_vld iss_rd=5 -> pending[5]=1; rn1=5 -> stall=1; second iss_rd=5 -> iss_rdy=0; ld writeback to r5 -> stall=0 the cycle after reg_wr is high, and iss_rdy for r5 returns to 1.
REQ-039 iss_rd=7 reserved in the same cycle that reg_wr=1 with wr=7 -> pending[7]=1 after that edge.
REQ-040 rn3=9 pending, read3=0 -> stall=0; read3=1 -> stall=1.
REQ-041 Transfer at edge N, then rst=1 at edge N+1 -> reg_wr=0, pending=0, all rdy outputs 0 while rst=1.
